// File: rtl/second_tick_multi.sv
// second_tick_multi
//
// Registered, multi-channel inhibit gate. Each channel evaluates
// cond = a & ~b, and the registered output is shaped by a selectable mode:
//   00 LEVEL  : out follows cond, one cycle late
//   01 RISE   : one-cycle pulse per 0->1 transition of cond between sampled cycles
//   10 LATCH  : out sets on cond and stays set until clr or reset
//   11 TOGGLE : out flips once per rising edge of cond
// Status outputs are an OR-reduced flag and a saturating hit counter that counts
// sampled cycles whose new out value is non-zero.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   sample enable; when low every register holds
//   clr      in   synchronous clear of out, edge history and hit_cnt (beats en)
//   mode     in   output mode select (see above)
//   a        in   [WIDTH] per-channel enable operand
//   b        in   [WIDTH] per-channel inhibit operand
//   out      out  [WIDTH] registered per-channel result
//   any_out  out  OR of the out register
//   hit_cnt  out  [CNT_W] saturating count of sampled cycles with non-zero new out

module second_tick_multi #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             any_out,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    ModeLevel  = 2'b00,
    ModeRise   = 2'b01,
    ModeLatch  = 2'b10,
    ModeToggle = 2'b11
  } mode_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] next_out;

  assign cond = a & ~b;
  // Rising edge relative to the last sampled cycle, not the last clock.
  assign rise = cond & ~prev_q;

  always_comb begin
    next_out = out_q;
    unique case (mode_e'(mode))
      ModeLevel:  next_out = cond;
      ModeRise:   next_out = rise;
      ModeLatch:  next_out = out_q | cond;
      ModeToggle: next_out = out_q ^ rise;
      default:    next_out = out_q;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    prev_d    = prev_q;
    hit_cnt_d = hit_cnt_q;
    if (clr) begin
      out_d     = '0;
      prev_d    = '0;
      hit_cnt_d = '0;
    end else if (en) begin
      out_d  = next_out;
      // History tracks cond in every mode so a switch into RISE/TOGGLE sees
      // true history and raises no spurious edge.
      prev_d = cond;
      if ((|next_out) && !(&hit_cnt_q)) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      prev_q    <= '0;
      hit_cnt_q <= '0;
    end else begin
      out_q     <= out_d;
      prev_q    <= prev_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign out     = out_q;
  assign any_out = |out_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_second_tick_multi.sv
// Directed bench for second_tick_multi (WIDTH=4, CNT_W=2 so saturation is reachable).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.

module tb_second_tick_multi;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             any_out;
  logic [CNT_W-1:0] hit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  second_tick_multi #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .out     (out),
    .any_out (any_out),
    .hit_cnt (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check out, any_out and hit_cnt together.
  task automatic chk3(input string tag, input logic [3:0] e_out, input logic [1:0] e_cnt);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".any"}, 32'(any_out), 32'(|e_out));
    chk({tag, ".cnt"}, 32'(hit_cnt), 32'(e_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    mode  = 2'b00;
    a     = '0;
    b     = '0;
    #1;
    chk3("reset", 4'b0000, 2'd0);
    #12;
    rst_n = 1'b1;
    tick();

    // LEVEL truth table
    en = 1'b1; mode = 2'b00;
    a = 4'b0000; b = 4'b0000; tick(); chk3("lvl00", 4'b0000, 2'd0);
    a = 4'b1111; b = 4'b0000; tick(); chk3("lvl10", 4'b1111, 2'd1);
    a = 4'b0000; b = 4'b1111; tick(); chk3("lvl01", 4'b0000, 2'd1);
    a = 4'b1111; b = 4'b1111; tick(); chk3("lvl11", 4'b0000, 2'd1);

    // RISE: single pulse, then second pulse after cond drops for one sample
    do_clr(); chk3("clr0", 4'b0000, 2'd0);
    mode = 2'b01; a = 4'b0001; b = 4'b0000;
    tick(); chk3("rise1", 4'b0001, 2'd1);
    tick(); chk3("rise2", 4'b0000, 2'd1);
    tick(); chk3("rise3", 4'b0000, 2'd1);
    b = 4'b0001; tick(); chk3("rise_lo", 4'b0000, 2'd1);
    b = 4'b0000; tick(); chk3("rise_p2", 4'b0001, 2'd2);
    tick(); chk3("rise_p2e", 4'b0000, 2'd2);

    // LATCH and clr priority
    do_clr();
    mode = 2'b10; a = 4'b0100;
    tick(); chk3("lat_set", 4'b0100, 2'd1);
    a = 4'b0000; tick(); chk3("lat_hold", 4'b0100, 2'd2);
    a = 4'b0100; clr = 1'b1; tick(); chk3("lat_clr", 4'b0000, 2'd0);
    clr = 1'b0; tick(); chk3("lat_reset", 4'b0100, 2'd1);

    // TOGGLE on cond[1]; counter saturates at 3
    do_clr();
    mode = 2'b11; a = 4'b0000;
    tick(); chk3("tog0", 4'b0000, 2'd0);
    a = 4'b0010; tick(); chk3("tog_e1", 4'b0010, 2'd1);
    tick(); chk3("tog_hold", 4'b0010, 2'd2);
    a = 4'b0000; tick(); chk3("tog_fall", 4'b0010, 2'd3);
    a = 4'b0010; tick(); chk3("tog_e2", 4'b0000, 2'd3);
    a = 4'b0000; tick(); chk3("tog_fall2", 4'b0000, 2'd3);
    a = 4'b0010; tick(); chk3("tog_e3", 4'b0010, 2'd3);

    // en gating: out/hit_cnt/prev frozen
    do_clr();
    mode = 2'b00; a = 4'b0001; b = 4'b0000;
    tick(); chk3("en_pre", 4'b0001, 2'd1);
    en = 1'b0; a = 4'b1111; tick(); chk3("en_off1", 4'b0001, 2'd1);
    b = 4'b1111; mode = 2'b11; tick(); chk3("en_off2", 4'b0001, 2'd1);
    // prev must still be 0001, so RISE sees no edge
    en = 1'b1; mode = 2'b01; a = 4'b0001; b = 4'b0000;
    tick(); chk3("en_prev", 4'b0000, 2'd1);

    // Saturation in LEVEL
    do_clr();
    mode = 2'b00; a = 4'b1111; b = 4'b0000;
    tick(); chk3("sat1", 4'b1111, 2'd1);
    tick(); chk3("sat2", 4'b1111, 2'd2);
    tick(); chk3("sat3", 4'b1111, 2'd3);
    tick(); chk3("sat4", 4'b1111, 2'd3);
    tick(); chk3("sat5", 4'b1111, 2'd3);

    // Mode change into LATCH keeps existing out bits
    do_clr();
    mode = 2'b00; a = 4'b1000;
    tick(); chk3("mchg_lvl", 4'b1000, 2'd1);
    mode = 2'b10; a = 4'b0000;
    tick(); chk3("mchg_lat", 4'b1000, 2'd2);

    // Async reset mid-operation
    do_clr();
    mode = 2'b10; a = 4'b1010;
    tick(); chk3("ar_set", 4'b1010, 2'd1);
    a = 4'b0000; tick(); chk3("ar_hold", 4'b1010, 2'd2);
    #2; rst_n = 1'b0;
    #1; chk3("ar_async", 4'b0000, 2'd0);
    #2; rst_n = 1'b1;
    a = 4'b1010; tick(); chk3("ar_resume", 4'b1010, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/second_tick_multi.md
Name: second_tick_multi

Overview:
- Parametrised, registered, multi-channel successor to the single-bit inhibit gate (out = a AND NOT b).
- Evaluates the inhibit condition per channel, registers the result, and applies a selectable output mode: level, rising-edge pulse, sticky latch or toggle.
- Drives an OR-reduced flag and a saturating hit counter for status and debug logic.
- Sits between input conditioning and downstream control logic that needs clean, clocked inhibit events.

Parameters:
- WIDTH, 4, number of independent channels (>=1)
- CNT_W, 8, width of the saturating hit counter (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  sample enable; when low, all state holds
- clr  input  1  synchronous clear of out, edge history and hit_cnt
- mode  input  2  00 LEVEL, 01 RISE, 10 LATCH, 11 TOGGLE
- a  input  WIDTH  per-channel enable operand
- b  input  WIDTH  per-channel inhibit operand
- out  output  WIDTH  registered per-channel result
- any_out  output  1  OR of out, combinational from the out register
- hit_cnt  output  CNT_W  number of sampled cycles with non-zero new out, saturating

Behaviour:
- cond[i] = a[i] & ~b[i]. This is combinational and internal only.
- State registers: out[WIDTH], prev[WIDTH] (last sampled cond), hit_cnt[CNT_W].
- Reset: rst_n low asynchronously forces out=0, prev=0, hit_cnt=0, so any_out=0. Release is synchronised by the surrounding design.
- Priority at each rising clk edge: clr > en > hold.
- clr=1: out<=0, prev<=0, hit_cnt<=0, regardless of en, mode, a or b.
- clr=0, en=0: every register holds. a, b and mode are ignored.
- clr=0, en=1: prev<=cond. out<=next_out, where next_out depends on mode:
  - LEVEL: next_out[i] = cond[i].
  - RISE: next_out[i] = cond[i] & ~prev[i]. This gives a one-cycle pulse per 0->1 transition of cond between sampled cycles.
  - LATCH: next_out[i] = out[i] | cond[i]. A channel stays set until clr or reset.
  - TOGGLE: next_out[i] = out[i] ^ (cond[i] & ~prev[i]). The channel flips once per rising edge of cond.
- Also on clr=0, en=1: if next_out != 0 and hit_cnt != all-ones, hit_cnt<=hit_cnt+1. At all-ones it holds (saturates, never wraps).
- Latency: a/b change to out is 1 clk (one sampled cycle when en gates sampling).
- RISE detection is relative to the last sampled cycle. Edges occurring while en=0 are seen only if cond differs at the next en=1 edge.
- prev updates in every mode. Switching into RISE or TOGGLE therefore uses true history and produces no spurious edge.
- A mode change takes effect at the next sampling edge. out is not cleared on a mode change. LATCH entered with out non-zero keeps those bits.
- Channels are fully independent: no cross-channel interaction except any_out and hit_cnt.
- WIDTH=1 must behave exactly as the single-bit inhibit gate registered by one cycle in LEVEL mode.

Test Plan:
- Truth table (WIDTH=4, LEVEL, en=1): a=0000 b=0000 -> out=0000; a=1111 b=0000 -> out=1111; a=0000 b=1111 -> out=0000; a=1111 b=1111 -> out=0000. Each result appears one clk after its stimulus. any_out follows out; hit_cnt=1 after the sequence.
- RISE: a=0001, b=0000 held for 3 clks -> out[0]=1 for exactly 1 clk, then 0. Then b=0001 for 1 clk and b=0000 again -> a second single pulse.
- LATCH + clr: a=0100 pulse for 1 clk -> out=0100, held after a returns to 0. clr=1 with a=0100 in the same cycle -> out=0000 (clr wins). The next en cycle with cond=0100 sets it again.
- TOGGLE: three separate rising edges of cond[1] -> out[1] sequence 1,0,1. Holding cond high does not toggle further.
- en gating and saturation (CNT_W=2): en=0 with changing a/b -> out, prev and hit_cnt frozen. With en=1 and a=1111, b=0000 for 5 clks in LEVEL -> hit_cnt 1,2,3,3,3.
- Async reset mid-operation: in LATCH with out=1010 and hit_cnt=2, drop rst_n between clk edges -> out=0000, any_out=0, hit_cnt=0 immediately, without a clock edge. After release, normal operation resumes at the next edge.
